// File: rtl/controlador_selecao.sv
// controlador_selecao
//   Two-key product selection sequencer for the vending machine keypad. Synchronises the raw
//   keypad lines, detects press events, builds the 4-bit selection code from two key indices,
//   enforces an entry timeout and issues one-cycle valid / error strobes.
//
// Ports
//   clock         in   1  system clock, rising edge
//   reset         in   1  asynchronous reset, active-high
//   tecla         in   4  raw keypad lines, one-hot per key, active-high
//   estado        in   2  vending FSM state; selection accepted only when 0
//   cancelar      in   1  synchronous abort of the current entry
//   digito        out  2  0 idle, 1 awaiting second key, 2 code complete
//   codigo        out  4  [3:2] first key index, [1:0] second key index
//   codigo_valido out  1  one-cycle strobe, codigo holds a complete selection
//   erro          out  1  one-cycle strobe, multi-key press or timeout
//
// Configuration
//   DEBOUNCE_EN   when defined, synced keys must be stable for DEBOUNCE_CICLOS clocks before
//                 they are used for edge detection.

module controlador_selecao #(
  parameter int unsigned TIMEOUT_CICLOS  = 50_000_000,
  parameter int unsigned DEBOUNCE_CICLOS = 500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] tecla,
  input  logic [1:0] estado,
  input  logic       cancelar,
  output logic [1:0] digito,
  output logic [3:0] codigo,
  output logic       codigo_valido,
  output logic       erro
);

  localparam int unsigned TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);

  typedef enum logic [1:0] {
    StOcioso    = 2'd0,
    StAguardaD2 = 2'd1,
    StFinaliza  = 2'd2
  } t_estado;

  logic [3:0] r_sync1, r_sync2, r_prev;
  logic [3:0] w_key;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= tecla;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned DW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS + 1) : 1;

  logic [3:0]    r_deb_val, r_deb_cand;
  logic [DW-1:0] r_deb_cnt;
  logic [DW-1:0] w_deb_cnt_nxt;

  // Counts consecutive clocks the synced value has differed from the debounced one while
  // staying identical to itself; a different candidate restarts at 1.
  always_comb begin
    w_deb_cnt_nxt = (r_sync2 == r_deb_cand) ? r_deb_cnt + 1'b1 : DW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_deb_val  <= '0;
      r_deb_cand <= '0;
      r_deb_cnt  <= '0;
    end else if (r_sync2 == r_deb_val) begin
      r_deb_cnt <= '0;
    end else if (w_deb_cnt_nxt >= DW'(DEBOUNCE_CICLOS)) begin
      r_deb_val <= r_sync2;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cand <= r_sync2;
      r_deb_cnt  <= w_deb_cnt_nxt;
    end
  end

  assign w_key = r_deb_val;
`else
  assign w_key = r_sync2;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_prev <= '0;
    else       r_prev <= w_key;
  end

  logic       w_press, w_multi, w_valid;
  logic [1:0] w_idx;

  assign w_press = (w_key != 4'd0) && (r_prev == 4'd0);
  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_multi = (w_key & (w_key - 4'd1)) != 4'd0;
  assign w_valid = w_press && !w_multi;

  always_comb begin
    w_idx = 2'd0;
    unique case (w_key)
      4'b0001: w_idx = 2'd0;
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  t_estado       r_state, w_state_nxt;
  logic [3:0]    r_codigo, w_codigo_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_erro, w_erro_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= StOcioso;
      r_codigo <= '0;
      r_timer  <= '0;
      r_erro   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_codigo <= w_codigo_nxt;
      r_timer  <= w_timer_nxt;
      r_erro   <= w_erro_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_codigo_nxt = r_codigo;
    w_timer_nxt  = '0;
    w_erro_nxt   = 1'b0;
    if (cancelar) begin
      w_state_nxt  = StOcioso;
      w_codigo_nxt = '0;
    end else begin
      unique case (r_state)
        StOcioso: begin
          if (w_press && (estado == 2'd0)) begin
            if (w_multi) begin
              w_erro_nxt = 1'b1;
            end else begin
              w_state_nxt  = StAguardaD2;
              w_codigo_nxt = {w_idx, 2'b00};
            end
          end
        end
        StAguardaD2: begin
          w_erro_nxt = w_press && w_multi;
          if (estado != 2'd0) begin
            w_state_nxt  = StOcioso;
            w_codigo_nxt = '0;
          end else if (w_valid) begin
            // A valid press beats a simultaneous timeout.
            w_state_nxt       = StFinaliza;
            w_codigo_nxt[1:0] = w_idx;
          end else if (r_timer == TIMER_MAX) begin
            w_state_nxt  = StOcioso;
            w_codigo_nxt = '0;
            w_erro_nxt   = 1'b1;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        StFinaliza: begin
          w_erro_nxt  = w_press && w_multi;
          w_state_nxt = StOcioso;
        end
        default: begin
          w_state_nxt  = StOcioso;
          w_codigo_nxt = '0;
        end
      endcase
    end
  end

  assign digito        = r_state;
  assign codigo        = r_codigo;
  assign codigo_valido = (r_state == StFinaliza);
  assign erro          = r_erro;

endmodule

// File: tb/tb_controlador_selecao.sv
module tb_controlador_selecao;

  localparam int unsigned TMO = 20;
  localparam int unsigned DEB = 4;
`ifdef DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  logic       clock;
  logic       reset;
  logic [3:0] tecla;
  logic [1:0] estado;
  logic       cancelar;
  logic [1:0] digito;
  logic [3:0] codigo;
  logic       codigo_valido;
  logic       erro;

  int n_run;
  int n_fail;

  controlador_selecao #(
    .TIMEOUT_CICLOS (TMO),
    .DEBOUNCE_CICLOS(DEB)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tecla        (tecla),
    .estado       (estado),
    .cancelar     (cancelar),
    .digito       (digito),
    .codigo       (codigo),
    .codigo_valido(codigo_valido),
    .erro         (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_run    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    tecla    = 4'd0;
    estado   = 2'd0;
    cancelar = 1'b0;
    tick(2);
    chk("rst_digito", 8'(digito), 8'd0);
    chk("rst_codigo", 8'(codigo), 8'd0);
    chk("rst_valido", 8'(codigo_valido), 8'd0);
    chk("rst_erro", 8'(erro), 8'd0);
    reset = 1'b0;
    tick(1);

    // 1: full selection 0100 then 1000 -> 1011
    tecla = 4'b0100;
    tick(LAT - 1);
    chk("t1_latency", 8'(digito), 8'd0);
    tick(1);
    chk("t1_d1_digito", 8'(digito), 8'd1);
    chk("t1_d1_codigo", 8'(codigo), 8'b1000);
    tecla = 4'd0;
    tick(LAT);
    tecla = 4'b1000;
    tick(LAT);
    chk("t1_fin_digito", 8'(digito), 8'd2);
    chk("t1_fin_codigo", 8'(codigo), 8'b1011);
    chk("t1_fin_valido", 8'(codigo_valido), 8'd1);
    chk("t1_fin_erro", 8'(erro), 8'd0);
    tick(1);
    chk("t1_after_digito", 8'(digito), 8'd0);
    chk("t1_after_valido", 8'(codigo_valido), 8'd0);
    chk("t1_after_codigo", 8'(codigo), 8'b1011);
    tecla = 4'd0;
    tick(LAT);

    // 2: timeout after first key
    tecla = 4'b0001;
    tick(LAT);
    chk("t2_d1_digito", 8'(digito), 8'd1);
    chk("t2_d1_codigo", 8'(codigo), 8'b0000);
    tecla = 4'd0;
    tick(TMO - 1);
    chk("t2_pre_digito", 8'(digito), 8'd1);
    chk("t2_pre_erro", 8'(erro), 8'd0);
    tick(1);
    chk("t2_tmo_digito", 8'(digito), 8'd0);
    chk("t2_tmo_erro", 8'(erro), 8'd1);
    chk("t2_tmo_codigo", 8'(codigo), 8'd0);
    chk("t2_tmo_valido", 8'(codigo_valido), 8'd0);
    tick(1);
    chk("t2_erro_1cyc", 8'(erro), 8'd0);

    // 3: multi-key press, then a held key yields one event only
    tecla = 4'b0011;
    tick(LAT);
    chk("t3_multi_erro", 8'(erro), 8'd1);
    chk("t3_multi_digito", 8'(digito), 8'd0);
    tick(1);
    chk("t3_multi_erro_1cyc", 8'(erro), 8'd0);
    tecla = 4'd0;
    tick(LAT);
    tecla = 4'b0010;
    tick(LAT);
    chk("t3_hold_digito", 8'(digito), 8'd1);
    chk("t3_hold_codigo", 8'(codigo), 8'b0100);
    tick(TMO);
    chk("t3_hold_tmo_erro", 8'(erro), 8'd1);
    chk("t3_hold_tmo_digito", 8'(digito), 8'd0);
    tick(10);
    chk("t3_hold_no_reentry", 8'(digito), 8'd0);
    chk("t3_hold_no_erro", 8'(erro), 8'd0);
    tecla = 4'd0;
    tick(LAT);

    // 4: cancel in the same clock the second key arrives
    tecla = 4'b0010;
    tick(LAT);
    chk("t4_d1_digito", 8'(digito), 8'd1);
    tecla = 4'd0;
    tick(LAT);
    tecla = 4'b0001;
    tick(LAT - 1);
    cancelar = 1'b1;
    tick(1);
    cancelar = 1'b0;
    chk("t4_cxl_digito", 8'(digito), 8'd0);
    chk("t4_cxl_codigo", 8'(codigo), 8'd0);
    chk("t4_cxl_valido", 8'(codigo_valido), 8'd0);
    chk("t4_cxl_erro", 8'(erro), 8'd0);
    tick(1);
    chk("t4_cxl_next_valido", 8'(codigo_valido), 8'd0);
    chk("t4_cxl_next_digito", 8'(digito), 8'd0);
    tecla = 4'd0;
    tick(LAT);

    // 5: vending FSM busy
    estado = 2'd2;
    tecla  = 4'b1000;
    tick(LAT);
    chk("t5_busy_digito", 8'(digito), 8'd0);
    chk("t5_busy_erro", 8'(erro), 8'd0);
    tecla = 4'd0;
    tick(LAT);
    estado = 2'd0;
    tecla  = 4'b0100;
    tick(LAT);
    chk("t5_d1_digito", 8'(digito), 8'd1);
    chk("t5_d1_codigo", 8'(codigo), 8'b1000);
    estado = 2'd1;
    tick(1);
    chk("t5_abort_digito", 8'(digito), 8'd0);
    chk("t5_abort_codigo", 8'(codigo), 8'd0);
    chk("t5_abort_erro", 8'(erro), 8'd0);
    estado = 2'd0;
    tecla  = 4'd0;
    tick(LAT);

    // Second key lands in the same clock the timeout would fire: entry completes
    tecla = 4'b0001;
    tick(LAT);
    chk("t7_d1_digito", 8'(digito), 8'd1);
    tecla = 4'd0;
    tick(TMO - LAT);
    tecla = 4'b1000;
    tick(LAT);
    chk("t7_race_digito", 8'(digito), 8'd2);
    chk("t7_race_codigo", 8'(codigo), 8'b0011);
    chk("t7_race_erro", 8'(erro), 8'd0);
    chk("t7_race_valido", 8'(codigo_valido), 8'd1);
    tecla = 4'd0;
    tick(LAT + 1);

`ifdef DEBOUNCE_EN
    // 6: short glitch invisible, longer pulse accepted after 3 + DEB clocks
    tecla = 4'b0001;
    tick(2);
    tecla = 4'd0;
    tick(10);
    chk("t6_glitch_digito", 8'(digito), 8'd0);
    tecla = 4'b0001;
    tick(6);
    tecla = 4'd0;
    chk("t6_pulse_early", 8'(digito), 8'd0);
    tick(1);
    chk("t6_pulse_digito", 8'(digito), 8'd1);
`else
    tecla = 4'b0100;
    tick(LAT);
    tecla = 4'd0;
    chk("t6_d1_digito", 8'(digito), 8'd1);
    chk("t6_d1_codigo", 8'(codigo), 8'b1000);
`endif

    // Asynchronous reset mid-entry, checked before any clock edge
    #2;
    reset = 1'b1;
    #1;
    chk("t6_arst_digito", 8'(digito), 8'd0);
    chk("t6_arst_codigo", 8'(codigo), 8'd0);
    chk("t6_arst_valido", 8'(codigo_valido), 8'd0);
    chk("t6_arst_erro", 8'(erro), 8'd0);
    tick(1);
    reset = 1'b0;
    tick(2);
    chk("t6_post_rst_digito", 8'(digito), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
